// File: rtl/div_fsm.sv
// div_fsm: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} after DATA_W iterations and stalls the
// execute stage while a divide is pending.
module div_fsm #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_div_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic              stall_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, DIV_ON, DIV_END} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  // Iteration datapath
  logic [2*DATA_W:0]   shifted;
  logic [DATA_W:0]     trial;
  logic [2*DATA_W:0]   iter;
  logic [DATA_W-1:0]   quo, rem;
  logic [DATA_W-1:0]   a_mag, b_mag;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return ~x + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Next-state, datapath and result computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    // Shift in, trial-subtract divisor from the partial remainder, restore on borrow.
    shifted = work_q << 1;
    trial   = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_q};
    iter    = shifted;
    if (!trial[DATA_W]) iter = {trial, shifted[DATA_W-1:1], 1'b1};
    quo     = iter[DATA_W-1:0];
    rem     = iter[2*DATA_W-1:DATA_W];

    // Magnitudes of the operands; unsigned mode passes them through.
    a_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? negate(opdata1_i) : opdata1_i;
    b_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? negate(opdata2_i) : opdata2_i;

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIVZERO;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = '0;
            work_d    = {{(DATA_W+1){1'b0}}, a_mag};
            divisor_d = b_mag;
            neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
          end
        end
      end
      DIVZERO: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          work_d = iter;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d  = DIV_END;
            cnt_d    = '0;
            result_d = {neg_rem_q ? negate(rem) : rem, neg_quo_q ? negate(quo) : quo};
            ready_d  = 1'b1;
          end
        end
      end
      DIV_END: begin
        if (!start_i) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign stall_o  = start_i & (state_q != DIV_END);

endmodule

// File: tb/tb_div_fsm.sv
// tb_div_fsm: scoreboard bench for div_fsm. Expected results come from a
// 64-bit behavioural division model and are queued at launch.
module tb_div_fsm;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_div_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stall_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] sq[$];
  logic [63:0] last_exp = '0;

  div_fsm #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference: divide in 64-bit arithmetic so the signed overflow case needs no special path.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    logic [63:0] qv, rv;
    if (b == 0) return 64'd0;
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Drive a request in the current cycle (called right after a negedge).
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
    if (push) sq.push_back(model(s, a, b));
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // From the accepting cycle: wait for ready_o, check latency, stall and result, then release.
  task automatic finish_div(input int lat, input string tag);
    int i;
    logic stall_ok;
    logic [63:0] exp;
    #1;
    stall_ok = stall_o;
    i = 0;
    while (i < 60) begin
      @(negedge clk);
      i++;
      if (i == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~signed_div_i;
      end
      if (ready_o) break;
      if (!stall_o) stall_ok = 1'b0;
    end
    exp = (sq.size() > 0) ? sq.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    chk({tag, "_latency"}, 64'(i), 64'(lat));
    chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, "_stall_done"}, 64'(stall_o), 64'd0);
    chk({tag, "_result"}, result_o, exp);
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_drop"}, 64'(ready_o), 64'd0);
    chk({tag, "_hold"}, result_o, exp);
    last_exp = exp;
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
    launch(s, a, b, 1'b1);
    finish_div((b == 0) ? 2 : 33, tag);
  endtask

  initial begin
    logic rose;
    rst = 1'b1; start_i = 1'b0; signed_div_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result_o, 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div(1'b0, 32'd100, 32'd7, "u100_7");
    chk("u100_7_const", last_exp, 64'h00000002_0000000E);
    @(negedge clk);
    run_div(1'b1, -32'sd7, 32'd2, "s_m7_2");
    chk("s_m7_2_const", last_exp, 64'hFFFFFFFF_FFFFFFFD);
    @(negedge clk);
    run_div(1'b1, 32'd7, -32'sd2, "s_7_m2");
    chk("s_7_m2_const", last_exp, 64'h00000001_FFFFFFFD);
    @(negedge clk);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "s_ovf");
    chk("s_ovf_const", last_exp, 64'h00000000_80000000);
    @(negedge clk);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, "u_max_1");
    @(negedge clk);
    run_div(1'b1, 32'h80000000, 32'd1, "s_min_1");
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] d;
      d = $urandom;
      if (d == 0) d = 32'd3;
      if (k >= 4) d = d >> 24;
      @(negedge clk);
      run_div(k[0], $urandom, d, "rand");
    end

    // Divide by zero
    @(negedge clk);
    run_div(1'b0, 32'd123, 32'd0, "div0");

    // Annul mid-divide, then a fresh request
    @(negedge clk);
    launch(1'b0, 32'd50, 32'd5, 1'b0);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    rose = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) rose = 1'b1;
    end
    chk("annul_no_ready", 64'(rose), 64'd0);
    chk("annul_result_kept", result_o, last_exp);
    run_div(1'b0, 32'd9, 32'd3, "after_annul");
    chk("after_annul_const", last_exp, 64'h00000000_00000003);

    // Reset mid-divide, start held through release
    @(negedge clk);
    launch(1'b1, -32'sd1000, 32'd3, 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_result", result_o, 64'd0);
    chk("rstmid_ready", 64'(ready_o), 64'd0);
    chk("rstmid_stall", 64'(stall_o), 64'd1);
    rst = 1'b0;
    opdata1_i = -32'sd1000; opdata2_i = 32'd3; signed_div_i = 1'b1;
    sq.push_back(model(1'b1, -32'sd1000, 32'd3));
    finish_div(33, "rst_restart");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
